// File: rtl/mac_if_pkg.sv
// -----------------------------------------------------------------------------
// mac_if_pkg
// Shared types and constants for the MAC receive path.
//   rx_frame_ctrl_state_t : receive sequencer states
//   PREAMBLE_BYTE/SFD_BYTE: GMII preamble and start-of-frame delimiter octets
//   rx_frame_status_t     : per-frame status word reported with each strobe
//   rx_status_ok()        : derives the "frame good" bit from the error flags
// -----------------------------------------------------------------------------
package mac_if_pkg;

    localparam int RX_LEN_W = 11;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_frame_ctrl_state_t;

    typedef struct packed {
        logic                ok;
        logic                crc_err;
        logic                runt;
        logic                giant;
        logic                phy_err;
        logic [RX_LEN_W-1:0] len;
    } rx_frame_status_t;

    // A frame is good only when no error flag is raised.
    function automatic logic rx_status_ok(input rx_frame_status_t s);
        return ~(s.crc_err | s.runt | s.giant | s.phy_err);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the receive statistics.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, clears the count
//   inc_i  : add one (ignored once the count is all-ones)
//   clr_i  : clear to zero; takes priority over inc_i
//   q_o    : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] q_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
// RX MAC frame sequencer sitting between the GMII receive stream and the CRC
// checker. Tracks preamble/SFD, counts frame bytes (FCS included), samples the
// checker verdict at end of frame and emits one registered status strobe per
// frame. Keeps saturating good/bad/alignment-error statistics.
//   clk, rst_n          : clock, synchronous active-low reset
//   gmii_rx_valid_i/er_i/data_i : GMII RX_DV, RX_ER, RXD
//   crc_error_i         : checker verdict, valid in the first cycle after RX_DV falls
//   stats_clr_i         : clear all statistics counters (wins over increments)
//   frame_done_o        : one-cycle status strobe
//   frame_*_o           : status of the last completed frame, held until the next strobe
//   good_cnt_o/bad_cnt_o/align_err_cnt_o : saturating statistics
// -----------------------------------------------------------------------------
module rx_frame_ctrl
    import mac_if_pkg::*;
#(
    parameter int MIN_FRAME_LEN      = 64,
    parameter int MAX_FRAME_LEN      = 1518,
    parameter int MAX_PREAMBLE_BYTES = 7,
    parameter int LEN_W              = RX_LEN_W,
    parameter int CNT_W              = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gmii_rx_valid_i,
    input  logic             gmii_rx_er_i,
    input  logic [7:0]       gmii_rx_data_i,
    input  logic             crc_error_i,
    input  logic             stats_clr_i,
    output logic             frame_done_o,
    output logic             frame_ok_o,
    output logic             frame_crc_err_o,
    output logic             frame_runt_o,
    output logic             frame_giant_o,
    output logic             frame_phy_err_o,
    output logic [LEN_W-1:0] frame_len_o,
    output logic [CNT_W-1:0] good_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o,
    output logic [CNT_W-1:0] align_err_cnt_o
);

    localparam int PRE_W = $clog2(MAX_PREAMBLE_BYTES + 1);

    rx_frame_ctrl_state_t state_q, state_d;
    logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 phy_err_q, phy_err_d;
    rx_frame_status_t     status_q, status_d;
    logic                 done_q, done_d;
    logic                 align_inc_s;
    logic                 good_inc_s;
    logic                 bad_inc_s;

    // Sequencer next-state, byte counting and end-of-frame status capture.
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        len_d       = len_q;
        phy_err_d   = phy_err_q;
        status_d    = status_q;
        done_d      = 1'b0;
        align_inc_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (gmii_rx_valid_i) begin
                    if (gmii_rx_data_i == PREAMBLE_BYTE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PRE_W'(1);
                    end else begin
                        // Mid-packet start: no preamble seen, so not an alignment error.
                        state_d = DROP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_valid_i) begin
                    state_d = IDLE;
                end else if (gmii_rx_data_i == PREAMBLE_BYTE) begin
                    if (pre_cnt_q == PRE_W'(MAX_PREAMBLE_BYTES)) begin
                        state_d     = DROP;
                        align_inc_s = 1'b1;
                    end else begin
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end
                end else if (gmii_rx_data_i == SFD_BYTE) begin
                    state_d   = DATA;
                    len_d     = {LEN_W{1'b0}};
                    phy_err_d = 1'b0;
                end else begin
                    state_d     = DROP;
                    align_inc_s = 1'b1;
                end
            end
            DATA: begin
                if (gmii_rx_valid_i) begin
                    if (len_q != {LEN_W{1'b1}}) begin
                        len_d = len_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        len_d = len_q;
                    end
                    if (gmii_rx_er_i) begin
                        phy_err_d = 1'b1;
                    end else begin
                        phy_err_d = phy_err_q;
                    end
                end else begin
                    // First idle cycle: the checker verdict is valid only now.
                    status_d.crc_err = crc_error_i;
                    status_d.runt    = (len_q < LEN_W'(MIN_FRAME_LEN));
                    status_d.giant   = (len_q > LEN_W'(MAX_FRAME_LEN));
                    status_d.phy_err = phy_err_q;
                    status_d.len     = len_q;
                    status_d.ok      = rx_status_ok(status_d);
                    done_d           = 1'b1;
                    state_d          = IDLE;
                end
            end
            DROP: begin
                if (!gmii_rx_valid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_cnt_q <= {PRE_W{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            phy_err_q <= 1'b0;
            status_q  <= '{ok: 1'b0, crc_err: 1'b0, runt: 1'b0, giant: 1'b0,
                           phy_err: 1'b0, len: {RX_LEN_W{1'b0}}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            len_q     <= len_d;
            phy_err_q <= phy_err_d;
            status_q  <= status_d;
            done_q    <= done_d;
        end
    end

    // Statistics advance on the strobe itself.
    assign good_inc_s = done_q & status_q.ok;
    assign bad_inc_s  = done_q & ~status_q.ok;

    sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (good_inc_s),
        .clr_i (stats_clr_i),
        .q_o   (good_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bad_inc_s),
        .clr_i (stats_clr_i),
        .q_o   (bad_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_align_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (align_inc_s),
        .clr_i (stats_clr_i),
        .q_o   (align_err_cnt_o)
    );

    assign frame_done_o    = done_q;
    assign frame_ok_o      = status_q.ok;
    assign frame_crc_err_o = status_q.crc_err;
    assign frame_runt_o    = status_q.runt;
    assign frame_giant_o   = status_q.giant;
    assign frame_phy_err_o = status_q.phy_err;
    assign frame_len_o     = status_q.len;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Directed bench for rx_frame_ctrl. Statistics counters are built narrow so
// that saturation can be reached with real frames.
// -----------------------------------------------------------------------------
module tb_rx_frame_ctrl;

    localparam int TB_CNT_W = 6;
    localparam int TB_LEN_W = 11;

    logic                clk;
    logic                rst_n;
    logic                gmii_rx_valid_i;
    logic                gmii_rx_er_i;
    logic [7:0]          gmii_rx_data_i;
    logic                crc_error_i;
    logic                stats_clr_i;
    logic                frame_done_o;
    logic                frame_ok_o;
    logic                frame_crc_err_o;
    logic                frame_runt_o;
    logic                frame_giant_o;
    logic                frame_phy_err_o;
    logic [TB_LEN_W-1:0] frame_len_o;
    logic [TB_CNT_W-1:0] good_cnt_o;
    logic [TB_CNT_W-1:0] bad_cnt_o;
    logic [TB_CNT_W-1:0] align_err_cnt_o;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int strobe_base;

    rx_frame_ctrl #(
        .MIN_FRAME_LEN      (64),
        .MAX_FRAME_LEN      (1518),
        .MAX_PREAMBLE_BYTES (7),
        .LEN_W              (TB_LEN_W),
        .CNT_W              (TB_CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gmii_rx_valid_i (gmii_rx_valid_i),
        .gmii_rx_er_i    (gmii_rx_er_i),
        .gmii_rx_data_i  (gmii_rx_data_i),
        .crc_error_i     (crc_error_i),
        .stats_clr_i     (stats_clr_i),
        .frame_done_o    (frame_done_o),
        .frame_ok_o      (frame_ok_o),
        .frame_crc_err_o (frame_crc_err_o),
        .frame_runt_o    (frame_runt_o),
        .frame_giant_o   (frame_giant_o),
        .frame_phy_err_o (frame_phy_err_o),
        .frame_len_o     (frame_len_o),
        .good_cnt_o      (good_cnt_o),
        .bad_cnt_o       (bad_cnt_o),
        .align_err_cnt_o (align_err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes away from the active edge.
    always @(negedge clk) begin
        if (frame_done_o === 1'b1) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one GMII beat, then wait past the edge that consumes it.
    task automatic drive(input logic v, input logic er, input logic [7:0] d);
        gmii_rx_valid_i = v;
        gmii_rx_er_i    = er;
        gmii_rx_data_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_head(input int npre);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
    endtask

    task automatic send_bytes(input int n, input int er_idx, input logic [7:0] d);
        for (int i = 0; i < n; i++) drive(1'b1, (i == er_idx), d ^ 8'(i));
    endtask

    // Full frame ending with the first idle cycle carrying the CRC verdict;
    // returns with the status strobe expected high.
    task automatic send_frame(input int nbytes, input logic crc, input int er_idx);
        send_head(7);
        send_bytes(nbytes, er_idx, 8'h3C);
        crc_error_i = crc;
        drive(1'b0, 1'b0, 8'h00);
        crc_error_i = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        gmii_rx_valid_i = 1'b0;
        gmii_rx_er_i    = 1'b0;
        gmii_rx_data_i  = 8'h00;
        crc_error_i     = 1'b0;
        stats_clr_i     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        check("rst_done",  frame_done_o, 64'd0);
        check("rst_ok",    frame_ok_o, 64'd0);
        check("rst_len",   frame_len_o, 64'd0);
        check("rst_good",  good_cnt_o, 64'd0);
        check("rst_bad",   bad_cnt_o, 64'd0);
        check("rst_align", align_err_cnt_o, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Good 64-byte frame
        send_frame(64, 1'b0, -1);
        check("a_done",  frame_done_o, 64'd1);
        check("a_ok",    frame_ok_o, 64'd1);
        check("a_len",   frame_len_o, 64'd64);
        check("a_crc",   frame_crc_err_o, 64'd0);
        check("a_runt",  frame_runt_o, 64'd0);
        check("a_giant", frame_giant_o, 64'd0);
        check("a_phy",   frame_phy_err_o, 64'd0);
        idle(1);
        check("a_done_1cyc", frame_done_o, 64'd0);
        check("a_ok_hold",   frame_ok_o, 64'd1);
        check("a_good",      good_cnt_o, 64'd1);
        check("a_bad",       bad_cnt_o, 64'd0);
        check("a_strobes",   strobe_cnt, 64'd1);

        // CRC error
        send_frame(64, 1'b1, -1);
        check("b_crc", frame_crc_err_o, 64'd1);
        check("b_ok",  frame_ok_o, 64'd0);
        check("b_len", frame_len_o, 64'd64);
        idle(1);
        check("b_bad",  bad_cnt_o, 64'd1);
        check("b_good", good_cnt_o, 64'd1);

        // Runt (63)
        send_frame(63, 1'b0, -1);
        check("runt_flag", frame_runt_o, 64'd1);
        check("runt_ok",   frame_ok_o, 64'd0);
        check("runt_len",  frame_len_o, 64'd63);
        idle(1);
        check("runt_bad",  bad_cnt_o, 64'd2);

        // Giant (1519)
        send_frame(1519, 1'b0, -1);
        check("giant_flag", frame_giant_o, 64'd1);
        check("giant_runt", frame_runt_o, 64'd0);
        check("giant_ok",   frame_ok_o, 64'd0);
        check("giant_len",  frame_len_o, 64'd1519);
        idle(1);
        check("giant_bad",  bad_cnt_o, 64'd3);

        // Maximum legal (1518)
        send_frame(1518, 1'b0, -1);
        check("max_ok",    frame_ok_o, 64'd1);
        check("max_giant", frame_giant_o, 64'd0);
        check("max_len",   frame_len_o, 64'd1518);
        idle(1);
        check("max_good",  good_cnt_o, 64'd2);

        // Alignment errors: 8x55 then D5, and 3x55 then AA
        strobe_base = strobe_cnt;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        send_bytes(5, -1, 8'h10);
        idle(2);
        check("align8_cnt", align_err_cnt_o, 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hAA);
        send_bytes(2, -1, 8'h10);
        idle(2);
        check("alignAA_cnt", align_err_cnt_o, 64'd2);
        check("align_nostrobe", strobe_cnt - strobe_base, 64'd0);
        send_frame(64, 1'b0, -1);
        check("post_align_ok", frame_ok_o, 64'd1);
        idle(1);
        check("post_align_good", good_cnt_o, 64'd3);

        // RX_ER on one byte mid-frame
        send_frame(64, 1'b0, 10);
        check("phy_flag", frame_phy_err_o, 64'd1);
        check("phy_ok",   frame_ok_o, 64'd0);
        check("phy_len",  frame_len_o, 64'd64);
        idle(1);
        check("phy_bad",  bad_cnt_o, 64'd4);

        // Zero data bytes after SFD
        send_frame(0, 1'b0, -1);
        check("zero_done", frame_done_o, 64'd1);
        check("zero_runt", frame_runt_o, 64'd1);
        check("zero_len",  frame_len_o, 64'd0);
        idle(1);
        check("zero_bad",  bad_cnt_o, 64'd5);

        // Reset mid-frame, remaining bytes dropped
        strobe_base = strobe_cnt;
        send_head(7);
        send_bytes(20, -1, 8'h33);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h33);
        rst_n = 1'b1;
        send_bytes(20, -1, 8'h33);
        idle(3);
        check("mrst_nostrobe", strobe_cnt - strobe_base, 64'd0);
        check("mrst_good",     good_cnt_o, 64'd0);
        check("mrst_bad",      bad_cnt_o, 64'd0);
        check("mrst_align",    align_err_cnt_o, 64'd0);
        check("mrst_ok",       frame_ok_o, 64'd0);
        send_frame(64, 1'b0, -1);
        check("mrst_next_ok", frame_ok_o, 64'd1);
        idle(1);
        check("mrst_next_good", good_cnt_o, 64'd1);

        // Clear coinciding with the strobe
        send_frame(64, 1'b0, -1);
        check("clr_strobe", frame_done_o, 64'd1);
        stats_clr_i = 1'b1;
        idle(1);
        stats_clr_i = 1'b0;
        check("clr_good",  good_cnt_o, 64'd0);
        check("clr_bad",   bad_cnt_o, 64'd0);
        check("clr_align", align_err_cnt_o, 64'd0);

        // Fill good_cnt to all-ones, then one more frame
        for (int n = 0; n < 63; n++) begin
            send_frame(64, 1'b0, -1);
            idle(1);
        end
        check("sat_full", good_cnt_o, 64'd63);
        send_frame(64, 1'b0, -1);
        check("sat_ok", frame_ok_o, 64'd1);
        idle(2);
        check("sat_hold", good_cnt_o, 64'd63);
        check("sat_bad",  bad_cnt_o, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
